// File: rtl/data_mem_ctrl.sv
// Single-port data memory behind a valid/ready request channel.
// Supports byte/half/word lanes, sign/zero-extended loads and a fixed-latency response.
module data_mem_ctrl #(
  parameter int    DEPTH       = 1024,
  parameter int    WAIT_CYCLES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic          accept;
  logic          misaligned;
  logic          out_of_range;
  logic          req_err;
  logic [1:0]    off;
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;
  logic [31:0]   rd_shift;
  logic [31:0]   load_val;
  logic [31:0]   wr_data;
  logic [3:0]    wr_be;

  assign off          = req_addr[1:0];
  assign word_idx     = req_addr[AW+1:2];
  assign accept       = req_valid && (state_q == IDLE);
  assign misaligned   = ((req_size == 2'b01) && off[0]) || ((req_size == 2'b10) && (off != 2'b00));
  assign out_of_range = |req_addr[31:AW+2];
  assign req_err      = (req_size == 2'b11) || misaligned || out_of_range;

  assign rd_word  = mem[word_idx];
  assign rd_shift = rd_word >> {off, 3'b000};
  assign wr_data  = req_wdata << {off, 3'b000};

  always_comb begin
    load_val = rd_word;
    wr_be    = 4'b1111;
    case (req_size)
      2'b00: begin
        load_val = {{24{req_signed & rd_shift[7]}}, rd_shift[7:0]};
        wr_be    = 4'b0001 << off;
      end
      2'b01: begin
        load_val = {{16{req_signed & rd_shift[15]}}, rd_shift[15:0]};
        wr_be    = 4'b0011 << off;
      end
      default: begin
        load_val = rd_word;
        wr_be    = 4'b1111;
      end
    endcase
  end

  // Storage is deliberately outside the reset domain: a committed store survives reset.
  always_ff @(posedge clk) begin
    if (accept && req_we && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Response fields are captured at accept and held until the RESP cycle ends.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        rdata_d   = '0;
        err_d     = 1'b0;
        if (req_valid) begin
          err_d   = req_err;
          rdata_d = (req_err || req_we) ? '0 : load_val;
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else cnt_d = cnt_q - 4'd1;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
        rdata_d    = '0;
        err_d      = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
